// File: rtl/uart_tx_arb_pkg.sv
// uart_tx_arb_pkg: constants shared by the UART transmit arbiter.
//   - FSM state encoding (ST_IDLE, ST_SEND, ST_WAIT_BUSY, ST_WAIT_DONE)
//   - requester indices (REQ_ENC = encoder bitstream, REQ_DBG = status/debug)
//   - default UART start timeout in clk cycles
//   - grant_onehot(): requester index to one-hot grant vector
package uart_tx_arb_pkg;

    localparam logic [1:0] ST_IDLE      = 2'd0;
    localparam logic [1:0] ST_SEND      = 2'd1;
    localparam logic [1:0] ST_WAIT_BUSY = 2'd2;
    localparam logic [1:0] ST_WAIT_DONE = 2'd3;

    localparam logic REQ_ENC = 1'b0;
    localparam logic REQ_DBG = 1'b1;

    localparam int unsigned TIMEOUT_CYC_DEF = 4096;

    function automatic logic [1:0] grant_onehot(input logic id);
        return (id == REQ_DBG) ? 2'b10 : 2'b01;
    endfunction

endpackage

// File: rtl/uart_tx_arb_if.sv
// uart_tx_arb_if: requester handshakes plus the UART start/busy link.
//   req0_* : requester 0 (encoder) valid/data/last in, ready pulse out
//   req1_* : requester 1 (status/debug), same meaning
//   send, send_data, is_sending : UART start pulse, byte, busy flag
//   grant, busy, tx_timeout     : arbiter status
// Modports: master = requesters and UART side, slave = the arbiter.
interface uart_tx_arb_if;
    logic       req0_valid;
    logic [7:0] req0_data;
    logic       req0_last;
    logic       req0_ready;
    logic       req1_valid;
    logic [7:0] req1_data;
    logic       req1_last;
    logic       req1_ready;
    logic       send;
    logic [7:0] send_data;
    logic       is_sending;
    logic [1:0] grant;
    logic       busy;
    logic       tx_timeout;

    modport master (
        output req0_valid, req0_data, req0_last, req1_valid, req1_data, req1_last, is_sending,
        input  req0_ready, req1_ready, send, send_data, grant, busy, tx_timeout
    );

    modport slave (
        input  req0_valid, req0_data, req0_last, req1_valid, req1_data, req1_last, is_sending,
        output req0_ready, req1_ready, send, send_data, grant, busy, tx_timeout
    );
endinterface

// File: rtl/uart_tx_arb_timer.sv
// uart_tx_arb_timer: UART start timeout counter, built only when
// UART_TX_ARB_TIMEOUT_EN is defined.
//   clk, rst : clock, asynchronous active-high reset
//   clr      : synchronous clear (held while not waiting for the UART)
//   en       : count enable
//   expire   : high while enabled and the count sits at TIMEOUT_CYC-1
module uart_tx_arb_timer
    import uart_tx_arb_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYC = TIMEOUT_CYC_DEF
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic expire
);
    localparam int unsigned CNT_W = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYC - 1);

    logic [CNT_W-1:0] cnt_q;

    assign expire = en && (cnt_q == CNT_LAST);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else if (clr) begin
            cnt_q <= '0;
        end else if (en && !expire) begin
            cnt_q <= cnt_q + 1'b1;
        end
    end
endmodule

// File: rtl/uart_tx_arb.sv
// uart_tx_arb: two-requester arbiter feeding a byte UART, one byte in flight.
//   clk, rst : clock, asynchronous active-high reset (shared with the UART)
//   bus      : uart_tx_arb_if.slave -- requester handshakes, UART link, status
// A byte with last=0 locks the arbiter to its requester until a last=1 byte
// completes; then the priority pointer moves to the other requester.
// Optional: define UART_TX_ARB_TIMEOUT_EN to abort when the UART never starts
// within TIMEOUT_CYC cycles (tx_timeout pulse); otherwise WAIT_BUSY waits forever.
module uart_tx_arb
    import uart_tx_arb_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYC = TIMEOUT_CYC_DEF
) (
    input logic          clk,
    input logic          rst,
    uart_tx_arb_if.slave bus
);
    if (TIMEOUT_CYC < 2) begin : g_bad_cfg
        $error("TIMEOUT_CYC must be at least 2");
    end

    logic [1:0] state_q, state_d;
    logic       ptr_q;
    logic       lock_valid_q;
    logic       lock_id_q;
    logic       owner_q;
    logic       last_q;
    logic [7:0] send_data_q;
    logic [1:0] grant_q;

    logic       win_any;
    logic       win_id;
    logic       win_last;
    logic [7:0] win_data;
    logic       capture;
    logic       done;
    logic       expire;
    logic       timeout_hit;

    // Lock overrides the pointer; the non-pointer requester only wins by default.
    always_comb begin
        win_any = 1'b0;
        win_id  = ptr_q;
        if (lock_valid_q) begin
            win_id  = lock_id_q;
            win_any = lock_id_q ? bus.req1_valid : bus.req0_valid;
        end else if (ptr_q ? bus.req1_valid : bus.req0_valid) begin
            win_any = 1'b1;
            win_id  = ptr_q;
        end else if (ptr_q ? bus.req0_valid : bus.req1_valid) begin
            win_any = 1'b1;
            win_id  = ~ptr_q;
        end
    end

    assign win_data = win_id ? bus.req1_data : bus.req0_data;
    assign win_last = win_id ? bus.req1_last : bus.req0_last;

    // rst gates the ready pulse so nothing is accepted while reset is held.
    assign capture     = (state_q == ST_IDLE) && win_any && !rst;
    assign done        = (state_q == ST_WAIT_DONE) && !bus.is_sending;
    assign timeout_hit = (state_q == ST_WAIT_BUSY) && !bus.is_sending && expire;

    assign bus.req0_ready = capture && (win_id == REQ_ENC);
    assign bus.req1_ready = capture && (win_id == REQ_DBG);
    assign bus.send       = (state_q == ST_SEND);
    assign bus.send_data  = send_data_q;
    assign bus.grant      = grant_q;
    assign bus.busy       = (state_q != ST_IDLE);

`ifdef UART_TX_ARB_TIMEOUT_EN
    logic tx_timeout_q;

    uart_tx_arb_timer #(
        .TIMEOUT_CYC(TIMEOUT_CYC)
    ) u_timer (
        .clk   (clk),
        .rst   (rst),
        .clr   (state_q != ST_WAIT_BUSY),
        .en    (state_q == ST_WAIT_BUSY),
        .expire(expire)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tx_timeout_q <= 1'b0;
        end else begin
            tx_timeout_q <= timeout_hit;
        end
    end

    assign bus.tx_timeout = tx_timeout_q;
`else
    assign expire         = 1'b0;
    assign bus.tx_timeout = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:      if (capture) state_d = ST_SEND;
            ST_SEND:      state_d = ST_WAIT_BUSY;
            ST_WAIT_BUSY: begin
                if (bus.is_sending) begin
                    state_d = ST_WAIT_DONE;
                end else if (timeout_hit) begin
                    state_d = ST_IDLE;
                end
            end
            ST_WAIT_DONE: if (done) state_d = ST_IDLE;
            default:      state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            ptr_q        <= REQ_ENC;
            lock_valid_q <= 1'b0;
            lock_id_q    <= REQ_ENC;
            owner_q      <= REQ_ENC;
            last_q       <= 1'b0;
            send_data_q  <= 8'h00;
            grant_q      <= 2'b00;
        end else begin
            state_q <= state_d;
            if (capture) begin
                send_data_q <= win_data;
                last_q      <= win_last;
                owner_q     <= win_id;
                grant_q     <= grant_onehot(win_id);
                if (!win_last) begin
                    lock_valid_q <= 1'b1;
                    lock_id_q    <= win_id;
                end
            end
            if (done) begin
                grant_q <= 2'b00;
                if (last_q) begin
                    lock_valid_q <= 1'b0;
                    ptr_q        <= ~owner_q;
                end
            end
            if (timeout_hit) begin
                grant_q      <= 2'b00;
                lock_valid_q <= 1'b0;
                ptr_q        <= ~owner_q;
            end
        end
    end
endmodule

// File: tb/tb_uart_tx_arb.sv
// tb_uart_tx_arb: directed self-checking bench for uart_tx_arb.
//   Drives both requesters and a small UART busy-flag model through the
//   interface; covers reset, single byte, contention, packet lock, timeout
//   (both builds of UART_TX_ARB_TIMEOUT_EN) and reset in the middle of a transfer.
module tb_uart_tx_arb;
    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    uart_tx_arb_if u_if ();

    uart_tx_arb #(
        .TIMEOUT_CYC(16)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(u_if)
    );

    int n_checks = 0;
    int n_fail   = 0;

    bit         uart_auto = 1'b1;
    int         uart_len  = 2;
    bit         auto_req  = 1'b0;
    logic [8:0] q0[$];
    logic [8:0] q1[$];
    logic [7:0] log_q[$];
    int         bad_ready = 0;

    // UART model: is_sending rises the cycle after send, stays up uart_len+1 cycles.
    initial begin
        int cnt;
        bit seen;
        cnt  = 0;
        seen = 1'b0;
        u_if.is_sending = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            if (rst) begin
                u_if.is_sending = 1'b0;
                cnt  = 0;
                seen = 1'b0;
            end else begin
                if (u_if.is_sending) begin
                    if (cnt == 0) u_if.is_sending = 1'b0;
                    else cnt = cnt - 1;
                end
                if (seen && uart_auto) begin
                    u_if.is_sending = 1'b1;
                    cnt = uart_len;
                end
                seen = u_if.send;
            end
        end
    end

    // Queue-driven requesters: present the queue head, pop it once accepted.
    initial begin
        bit a0, a1;
        forever begin
            @(negedge clk);
            a0 = u_if.req0_ready;
            a1 = u_if.req1_ready;
            @(posedge clk);
            #1;
            if (auto_req) begin
                if (a0 && q0.size() > 0) q0.delete(0);
                if (a1 && q1.size() > 0) q1.delete(0);
                u_if.req0_valid = (q0.size() > 0);
                u_if.req1_valid = (q1.size() > 0);
                if (q0.size() > 0) {u_if.req0_last, u_if.req0_data} = q0[0];
                if (q1.size() > 0) {u_if.req1_last, u_if.req1_data} = q1[0];
            end
        end
    end

    // Record every byte handed to the UART; flag ready outside IDLE.
    initial begin
        forever begin
            @(negedge clk);
            if (u_if.send) log_q.push_back(u_if.send_data);
            if (u_if.busy && (u_if.req0_ready || u_if.req1_ready)) bad_ready++;
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic apply_reset();
        auto_req = 1'b0;
        u_if.req0_valid = 1'b0;
        u_if.req1_valid = 1'b0;
        rst = 1'b1;
        q0.delete();
        q1.delete();
        repeat (2) @(posedge clk);
        #2;
        rst = 1'b0;
        log_q.delete();
        bad_ready = 0;
    endtask

    task automatic test_reset();
        u_if.req0_valid = 1'b1; u_if.req0_data = 8'h5A; u_if.req0_last = 1'b1;
        u_if.req1_valid = 1'b1; u_if.req1_data = 8'h3C; u_if.req1_last = 1'b1;
        tick();
        n_checks++; if (u_if.send !== 1'b0) begin n_fail++; $display("FAIL reset_send: got %b want 0", u_if.send); end
        n_checks++; if (u_if.send_data !== 8'h00) begin n_fail++; $display("FAIL reset_send_data: got %h want 00", u_if.send_data); end
        n_checks++; if (u_if.req0_ready !== 1'b0) begin n_fail++; $display("FAIL reset_req0_ready: got %b want 0", u_if.req0_ready); end
        n_checks++; if (u_if.req1_ready !== 1'b0) begin n_fail++; $display("FAIL reset_req1_ready: got %b want 0", u_if.req1_ready); end
        n_checks++; if (u_if.grant !== 2'b00) begin n_fail++; $display("FAIL reset_grant: got %b want 00", u_if.grant); end
        n_checks++; if (u_if.busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", u_if.busy); end
        n_checks++; if (u_if.tx_timeout !== 1'b0) begin n_fail++; $display("FAIL reset_tx_timeout: got %b want 0", u_if.tx_timeout); end
        rst = 1'b0;
        #1;
        // ptr resets to requester 0
        n_checks++; if (u_if.req0_ready !== 1'b1) begin n_fail++; $display("FAIL reset_ptr_req0_ready: got %b want 1", u_if.req0_ready); end
        n_checks++; if (u_if.req1_ready !== 1'b0) begin n_fail++; $display("FAIL reset_ptr_req1_ready: got %b want 0", u_if.req1_ready); end
        u_if.req0_valid = 1'b0;
        u_if.req1_valid = 1'b0;
        tick();
    endtask

    task automatic test_single();
        uart_auto = 1'b1;
        uart_len  = 2;
        tick();
        u_if.req0_valid = 1'b1; u_if.req0_data = 8'hA5; u_if.req0_last = 1'b1;
        #1;
        n_checks++; if (u_if.req0_ready !== 1'b1) begin n_fail++; $display("FAIL single_ready0: got %b want 1", u_if.req0_ready); end
        n_checks++; if (u_if.req1_ready !== 1'b0) begin n_fail++; $display("FAIL single_ready1: got %b want 0", u_if.req1_ready); end
        tick();
        u_if.req0_valid = 1'b0;
        n_checks++; if (u_if.send !== 1'b1) begin n_fail++; $display("FAIL single_send: got %b want 1", u_if.send); end
        n_checks++; if (u_if.send_data !== 8'hA5) begin n_fail++; $display("FAIL single_send_data: got %h want a5", u_if.send_data); end
        n_checks++; if (u_if.grant !== 2'b01) begin n_fail++; $display("FAIL single_grant_send: got %b want 01", u_if.grant); end
        n_checks++; if (u_if.busy !== 1'b1) begin n_fail++; $display("FAIL single_busy: got %b want 1", u_if.busy); end
        tick();
        n_checks++; if (u_if.send !== 1'b0) begin n_fail++; $display("FAIL single_send_one_cycle: got %b want 0", u_if.send); end
        n_checks++; if (u_if.send_data !== 8'hA5) begin n_fail++; $display("FAIL single_data_held: got %h want a5", u_if.send_data); end
        repeat (3) tick();
        n_checks++; if (u_if.grant !== 2'b01) begin n_fail++; $display("FAIL single_grant_wait_done: got %b want 01", u_if.grant); end
        tick();
        n_checks++; if (u_if.grant !== 2'b00) begin n_fail++; $display("FAIL single_grant_idle: got %b want 00", u_if.grant); end
        n_checks++; if (u_if.busy !== 1'b0) begin n_fail++; $display("FAIL single_busy_idle: got %b want 0", u_if.busy); end
    endtask

    task automatic test_contention();
        logic [7:0] exp_q[4];
        exp_q = '{8'h11, 8'h22, 8'h13, 8'h24};
        apply_reset();
        uart_auto = 1'b1;
        uart_len  = 2;
        q0 = '{9'h111, 9'h113};
        q1 = '{9'h122, 9'h124};
        auto_req = 1'b1;
        for (int i = 0; i < 200 && log_q.size() < 4; i++) tick();
        n_checks++; if (log_q.size() != 4) begin n_fail++; $display("FAIL contention_count: got %0d want 4", log_q.size()); end
        for (int i = 0; i < 4; i++) begin
            n_checks++;
            if (i >= log_q.size()) begin
                n_fail++; $display("FAIL contention_byte%0d: got none want %h", i, exp_q[i]);
            end else if (log_q[i] !== exp_q[i]) begin
                n_fail++; $display("FAIL contention_byte%0d: got %h want %h", i, log_q[i], exp_q[i]);
            end
        end
        auto_req = 1'b0;
        u_if.req0_valid = 1'b0;
        u_if.req1_valid = 1'b0;
    endtask

    task automatic test_lock();
        logic [7:0] exp_q[5];
        exp_q = '{8'hA1, 8'hA2, 8'hA3, 8'hB1, 8'hB2};
        apply_reset();
        uart_auto = 1'b1;
        uart_len  = 2;
        q1 = '{9'h0A1, 9'h0A2, 9'h1A3};
        auto_req = 1'b1;
        for (int i = 0; i < 50 && log_q.size() < 1; i++) tick();
        // ptr still points at requester 0 here; only the lock keeps requester 1 ahead.
        q0 = '{9'h1B1, 9'h1B2};
        for (int i = 0; i < 300 && log_q.size() < 5; i++) tick();
        n_checks++; if (log_q.size() != 5) begin n_fail++; $display("FAIL lock_count: got %0d want 5", log_q.size()); end
        for (int i = 0; i < 5; i++) begin
            n_checks++;
            if (i >= log_q.size()) begin
                n_fail++; $display("FAIL lock_byte%0d: got none want %h", i, exp_q[i]);
            end else if (log_q[i] !== exp_q[i]) begin
                n_fail++; $display("FAIL lock_byte%0d: got %h want %h", i, log_q[i], exp_q[i]);
            end
        end
        n_checks++; if (bad_ready !== 0) begin n_fail++; $display("FAIL ready_outside_idle: got %0d want 0", bad_ready); end
        auto_req = 1'b0;
        u_if.req0_valid = 1'b0;
        u_if.req1_valid = 1'b0;
    endtask

    task automatic test_timeout();
        int early;
        apply_reset();
        uart_auto = 1'b0;
        tick();
        u_if.req0_valid = 1'b1; u_if.req0_data = 8'hC3; u_if.req0_last = 1'b0;
        tick();
        u_if.req0_valid = 1'b0;
        n_checks++; if (u_if.send !== 1'b1) begin n_fail++; $display("FAIL timeout_send: got %b want 1", u_if.send); end
        tick();
        early = 0;
        for (int i = 0; i < 15; i++) begin
            tick();
            if (u_if.tx_timeout !== 1'b0 || u_if.busy !== 1'b1) early++;
        end
        n_checks++; if (early !== 0) begin n_fail++; $display("FAIL timeout_early: got %0d bad cycles want 0", early); end
        tick();
`ifdef UART_TX_ARB_TIMEOUT_EN
        n_checks++; if (u_if.tx_timeout !== 1'b1) begin n_fail++; $display("FAIL timeout_pulse: got %b want 1", u_if.tx_timeout); end
        n_checks++; if (u_if.grant !== 2'b00) begin n_fail++; $display("FAIL timeout_grant: got %b want 00", u_if.grant); end
        n_checks++; if (u_if.busy !== 1'b0) begin n_fail++; $display("FAIL timeout_busy: got %b want 0", u_if.busy); end
        tick();
        n_checks++; if (u_if.tx_timeout !== 1'b0) begin n_fail++; $display("FAIL timeout_one_cycle: got %b want 0", u_if.tx_timeout); end
        // lock released and ptr advanced: requester 1 now wins
        u_if.req0_valid = 1'b1; u_if.req0_data = 8'hD0; u_if.req0_last = 1'b1;
        u_if.req1_valid = 1'b1; u_if.req1_data = 8'hD1; u_if.req1_last = 1'b1;
        #1;
        n_checks++; if (u_if.req1_ready !== 1'b1) begin n_fail++; $display("FAIL timeout_ptr_req1: got %b want 1", u_if.req1_ready); end
        n_checks++; if (u_if.req0_ready !== 1'b0) begin n_fail++; $display("FAIL timeout_ptr_req0: got %b want 0", u_if.req0_ready); end
        u_if.req0_valid = 1'b0;
        u_if.req1_valid = 1'b0;
`else
        n_checks++; if (u_if.tx_timeout !== 1'b0) begin n_fail++; $display("FAIL notimeout_pulse: got %b want 0", u_if.tx_timeout); end
        n_checks++; if (u_if.busy !== 1'b1) begin n_fail++; $display("FAIL notimeout_busy: got %b want 1", u_if.busy); end
        n_checks++; if (u_if.grant !== 2'b01) begin n_fail++; $display("FAIL notimeout_grant: got %b want 01", u_if.grant); end
        early = 0;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (u_if.tx_timeout !== 1'b0 || u_if.busy !== 1'b1) early++;
        end
        n_checks++; if (early !== 0) begin n_fail++; $display("FAIL notimeout_wait: got %0d bad cycles want 0", early); end
`endif
        uart_auto = 1'b1;
    endtask

    task automatic test_reset_mid();
        apply_reset();
        uart_auto = 1'b1;
        uart_len  = 6;
        tick();
        u_if.req1_valid = 1'b1; u_if.req1_data = 8'hE7; u_if.req1_last = 1'b0;
        tick();
        u_if.req1_valid = 1'b0;
        repeat (3) tick();
        n_checks++; if (u_if.grant !== 2'b10) begin n_fail++; $display("FAIL mid_grant_before: got %b want 10", u_if.grant); end
        n_checks++; if (u_if.busy !== 1'b1) begin n_fail++; $display("FAIL mid_busy_before: got %b want 1", u_if.busy); end
        rst = 1'b1;
        #1;
        n_checks++; if (u_if.busy !== 1'b0) begin n_fail++; $display("FAIL mid_busy_async: got %b want 0", u_if.busy); end
        n_checks++; if (u_if.grant !== 2'b00) begin n_fail++; $display("FAIL mid_grant_async: got %b want 00", u_if.grant); end
        n_checks++; if (u_if.send_data !== 8'h00) begin n_fail++; $display("FAIL mid_send_data_async: got %h want 00", u_if.send_data); end
        n_checks++; if (u_if.send !== 1'b0) begin n_fail++; $display("FAIL mid_send_async: got %b want 0", u_if.send); end
        @(posedge clk);
        #2;
        rst = 1'b0;
        u_if.req0_valid = 1'b1; u_if.req0_data = 8'hF0; u_if.req0_last = 1'b1;
        u_if.req1_valid = 1'b1; u_if.req1_data = 8'hF1; u_if.req1_last = 1'b1;
        #1;
        n_checks++; if (u_if.req0_ready !== 1'b1) begin n_fail++; $display("FAIL mid_after_req0: got %b want 1", u_if.req0_ready); end
        n_checks++; if (u_if.req1_ready !== 1'b0) begin n_fail++; $display("FAIL mid_after_req1: got %b want 0", u_if.req1_ready); end
        u_if.req0_valid = 1'b0;
        u_if.req1_valid = 1'b0;
        tick();
    endtask

    initial begin
        rst = 1'b1;
        u_if.req0_valid = 1'b0; u_if.req0_data = 8'h00; u_if.req0_last = 1'b0;
        u_if.req1_valid = 1'b0; u_if.req1_data = 8'h00; u_if.req1_last = 1'b0;
        #3;
        test_reset();
        test_single();
        test_contention();
        test_lock();
        test_timeout();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
